// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the 16x32 register file: merges queued writebacks
// with interrupt context saves (PC -> PC_REG, flags -> FLAG_REG) onto one write port.
module regfile_wb_ctrl #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [3:0]  PC_REG   = 4'd12,
   parameter logic [3:0]  FLAG_REG = 4'd13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [3:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        interrupt,
   input  logic [31:0] pc,
   input  logic [1:0]  flags_in,
   output logic        isWb,
   output logic [3:0]  rd_ra,
   output logic [31:0] data,
   output logic        irq_ack,
   output logic        busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [3:0]  rd;
      logic [31:0] data;
   } wb_req_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SAVE_PC    = 2'd1,
      SAVE_FLAGS = 2'd2,
      ACK        = 2'd3
   } state_t;

   // Writeback FIFO
   wb_req_t       mem [DEPTH];
   wb_req_t       head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   // FSM and interrupt capture
   state_t        state;
   state_t        state_n;
   logic          irq_prev;
   logic          irq_pend;
   logic          irq_pend_n;
   logic          irq_take;
   logic [31:0]   save_pc;
   logic [1:0]    save_flags;

   logic          is_wb_n;
   logic [3:0]    rd_ra_n;
   logic [31:0]   data_n;
   logic          irq_ack_n;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign wb_ready = !full;
   assign push     = wb_valid && !full;
   assign head     = mem[rd_ptr];
   assign busy     = !empty || (state != IDLE);

   // New interrupt accepted only with nothing outstanding and the FSM idle
   assign irq_take = interrupt && !irq_prev && !irq_pend && (state == IDLE);

   // FIFO storage needs no reset; validity is tracked by count
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{rd: wb_rd, data: wb_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_prev   <= 1'b0;
         save_pc    <= '0;
         save_flags <= '0;
      end else begin
         irq_prev <= interrupt;
         if (irq_take) begin
            save_pc    <= pc;
            save_flags <= flags_in;
         end
      end
   end

   // State and registered write-port outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         irq_pend <= 1'b0;
         isWb     <= 1'b0;
         rd_ra    <= '0;
         data     <= '0;
         irq_ack  <= 1'b0;
      end else begin
         state    <= state_n;
         irq_pend <= irq_pend_n;
         isWb     <= is_wb_n;
         rd_ra    <= rd_ra_n;
         data     <= data_n;
         irq_ack  <= irq_ack_n;
      end
   end

   // Pending interrupt beats the FIFO head; pops stall for the whole save
   always_comb begin
      state_n    = state;
      irq_pend_n = irq_pend;
      is_wb_n    = 1'b0;
      rd_ra_n    = rd_ra;
      data_n     = data;
      irq_ack_n  = 1'b0;
      pop        = 1'b0;

      if (irq_take) begin
         irq_pend_n = 1'b1;
      end

      case (state)
         IDLE: begin
            if (irq_pend) begin
               state_n    = SAVE_PC;
               irq_pend_n = 1'b0;
               is_wb_n    = 1'b1;
               rd_ra_n    = PC_REG;
               data_n     = save_pc;
            end else if (!empty) begin
               pop     = 1'b1;
               is_wb_n = 1'b1;
               rd_ra_n = head.rd;
               data_n  = head.data;
            end
         end
         SAVE_PC: begin
            state_n = SAVE_FLAGS;
            is_wb_n = 1'b1;
            rd_ra_n = FLAG_REG;
            data_n  = {30'b0, save_flags};
         end
         SAVE_FLAGS: begin
            state_n   = ACK;
            irq_ack_n = 1'b1;
         end
         ACK: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule
